// File: rtl/fetch_queue.sv
// Fetch-to-decode circular queue, DEPTH entries of {pc, instr}; push-to-head latency 1, no bypass.
// in_ready drops only when full and out_valid only when empty, both from registered count; flush beats push/pop.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_head = r_mem[r_rd_ptr];

    // Stale storage is never cleared, so the head is masked whenever the queue is empty.
    assign out_pc    = out_valid ? w_head[63:32] : 32'h0;
    assign out_instr = out_valid ? w_head[31:0]  : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values 2, 4, 8, 16 (power of two).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  fetch side presents an entry this cycle.
REQ-006 in_pc  input  32  PC of presented instruction.
REQ-007 in_instr  input  32  instruction word read from imem at in_pc.
REQ-008 in_ready  output  1  queue accepts an entry this cycle.
REQ-009 out_valid  output  1  head entry available to decode.
REQ-010 out_pc  output  32  PC of head entry.
REQ-011 out_instr  output  32  instruction of head entry.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 flush  input  1  discard all entries (branch/jump redirect).
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage: DEPTH entries of {pc[31:0], instr[31:0]}, circular buffer; read and write pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-016 Push: when in_valid && in_ready at a rising edge, write {in_pc, in_instr} at the write pointer, advance write pointer by 1.
REQ-017 Pop: when out_valid && out_ready at a rising edge, advance read pointer by 1.
REQ-018 in_ready = (count < DEPTH); combinational from registered state only, never from in_valid or out_ready.
REQ-019 out_valid = (count != 0); combinational from registered state only.
REQ-020 out_pc/out_instr: head entry contents when out_valid=1; forced to 32'h0 when out_valid=0.
REQ-021 No bypass: an entry pushed into an empty queue appears at out_valid one cycle after the push edge (latency 1).
REQ-022 Simultaneous push and pop in the same cycle with 0 < count < DEPTH: both occur, count unchanged.
REQ-023 Full (count=DEPTH): in_ready=0, in_valid ignored; a pop that cycle lowers count to DEPTH-1, push accepted no earlier than the next cycle.
REQ-024 Empty (count=0): out_ready ignored, no pointer or count change from it.
REQ-025 Order: entries leave in exactly the order accepted; no entry duplicated or dropped except by flush/reset.
REQ-026 Flush: at a rising edge with flush=1, both pointers and count return to 0; any push or pop in that same cycle is discarded (flush has priority).
REQ-027 After flush edge: out_valid=0, in_ready=1; a push in the following cycle is accepted normally.
REQ-028 count update: count_next = count + push - pop; never exceeds DEPTH, never underflows.
REQ-029 Storage contents are not cleared by flush or reset; only pointers/count are, and REQ-020 masks stale data.

Reset
REQ-030 While rst=1, asynchronously and independent of clk: read pointer=0, write pointer=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-031 Reset asserted mid-operation (queue partially full, push/pop active) discards all entries immediately; no push or pop occurs on any edge while rst=1.
REQ-032 After rst deasserts, the first rising edge may accept a push.

Verification
REQ-033 Reset then push {pc=0x0, instr=0x00500093} single cycle, out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, count=1.
REQ-034 DEPTH=4, out_ready=0, push pcs 0x0,0x4,0x8,0xC,0x10 on consecutive cycles -> in_ready=0 after fourth push, 0x10 not accepted, count=4; then pop four -> order 0x0,0x4,0x8,0xC.
REQ-035 Streaming: in_valid=1 and out_ready=1 every cycle, pc stepping by 4 from 0x0 for 20 cycles -> count stays 1 after first cycle, outputs 0x0..0x4C in order across pointer wrap.
REQ-036 Queue holding 3 entries, flush=1 with in_valid=1 (pc=0x100) and out_ready=1 same cycle -> next cycle count=0, out_valid=0, out_pc=0, 0x100 absent; push 0x200 next cycle -> appears as head.
REQ-037 Queue holding 2 entries, rst pulsed high for 3 ns between clock edges -> out_valid=0, count=0, in_ready=1 immediately, before next edge.
REQ-038 Bench runs all scenarios at DEPTH=2 and DEPTH=4 with a reference model checking order and count every cycle.
